gate_bist_ctrl: RTL

Built-in self-test sequencer for a single 2-input combinational gate. On `start`, it drives the gate's inputs through all four input combinations, waits a programmable settle time, and samples the gate output. It compares each sample against an expected truth table and reports a mismatch count and a pass flag. It sits beside the gate-level cells (for example `and_gate`) and replaces hand-written directed sweeps with a reusable, synthesizable checker.

---
 rtl/gate_bist_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gate_bist_ctrl.sv
// rtl/gate_bist_ctrl.sv - BIST sequencer sweeping a 2-input gate through all four vectors.
// Optional failure capture ports enabled by defining GATE_BIST_FAIL_CAPTURE_EN.
module gate_bist_ctrl #(
  parameter int         SETTLE_CYCLES = 2,
  parameter int         PASSES        = 1,
  parameter logic [3:0] EXP_TT        = 4'b1000,
  parameter int         ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             drv_a,
  output logic             drv_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef GATE_BIST_FAIL_CAPTURE_EN
  ,
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic             fail_y
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE_S} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

  state_t           state, state_nxt;
  logic [1:0]       vec;
  logic [3:0]       pcnt;
  logic [7:0]       cnt;
  logic             mismatch;
  logic [ERR_W-1:0] err_nxt;

  assign mismatch = (state == CHECK) && !abort && (dut_y != EXP_TT[vec]);
  assign err_nxt  = (mismatch && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = SETTLE;
      SETTLE: begin
        if (abort)                    state_nxt = IDLE;
        else if (cnt == SETTLE_LAST)  state_nxt = CHECK;
      end
      CHECK: begin
        if (abort)                                   state_nxt = IDLE;
        else if (vec != 2'd3 || pcnt != PASS_LAST)   state_nxt = SETTLE;
        else                                         state_nxt = DONE_S;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    drv_a = 1'b0;
    drv_b = 1'b0;
    case (state)
      SETTLE, CHECK: begin
        busy  = 1'b1;
        drv_a = vec[1];
        drv_b = vec[0];
      end
      DONE_S:  done = 1'b1;
      default: ;
    endcase
  end

  // pass is loaded on the CHECK->DONE edge so it is already valid during the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec     <= '0;
      pcnt    <= '0;
      cnt     <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          vec     <= '0;
          pcnt    <= '0;
          cnt     <= '0;
          err_cnt <= '0;
          pass    <= 1'b0;
        end
        SETTLE: begin
          if (abort)                   pass <= 1'b0;
          else if (cnt != SETTLE_LAST) cnt  <= cnt + 8'd1;
        end
        CHECK: begin
          if (abort) begin
            pass <= 1'b0;
          end else begin
            err_cnt <= err_nxt;
            cnt     <= '0;
            if (vec != 2'd3) begin
              vec <= vec + 2'd1;
            end else if (pcnt != PASS_LAST) begin
              vec  <= '0;
              pcnt <= pcnt + 4'd1;
            end else begin
              pass <= (err_nxt == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_BIST_FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_y     <= 1'b0;
    end else if (state == IDLE && start) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_y     <= 1'b0;
    end else if (mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= vec;
      fail_y     <= dut_y;
    end
  end
`endif

endmodule
